// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester and FIFO write-port bundle for fifo_wr_arbiter
// src_valid/src_data/src_last/src_ready : per-source burst handshake, source i data at [i*DW +: DW]
// fifo_w_req/fifo_data_i                : FIFO write strobe and word
// fifo_full/fifo_w_cnt                  : FIFO full flag and occupancy in DW-words
// busy/cur_src                          : arbiter status and current/last granted source
interface fifo_wr_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DW     = 32,
    parameter int WCNT_W = 6
);
    localparam int SW = $clog2(N_SRC);
    logic [N_SRC-1:0]    src_valid;
    logic [N_SRC*DW-1:0] src_data;
    logic [N_SRC-1:0]    src_last;
    logic [N_SRC-1:0]    src_ready;
    logic                fifo_w_req;
    logic [DW-1:0]       fifo_data_i;
    logic                fifo_full;
    logic [WCNT_W-1:0]   fifo_w_cnt;
    logic                busy;
    logic [SW-1:0]       cur_src;
    modport master (
        output src_valid, src_data, src_last, fifo_full, fifo_w_cnt,
        input  src_ready, fifo_w_req, fifo_data_i, busy, cur_src
    );
    modport slave (
        input  src_valid, src_data, src_last, fifo_full, fifo_w_cnt,
        output src_ready, fifo_w_req, fifo_data_i, busy, cur_src
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst arbiter sharing one FIFO write port between N_SRC sources, header word per burst
// clk_w, rst_n (synchronous, active-low) plus bus (fifo_wr_arbiter_if.slave):
//   sources in: src_valid, src_data, src_last; sources out: src_ready
//   FIFO out: fifo_w_req, fifo_data_i; FIFO in: fifo_full, fifo_w_cnt; status out: busy, cur_src
// Define FIFO_ARB_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fifo_wr_arbiter #(
    parameter int         N_SRC     = 4,
    parameter int         DW        = 32,
    parameter int         MAX_BURST = 16,
    parameter int         DEPTH_W   = 64,
    parameter int         WCNT_W    = 6,
    parameter logic [7:0] HDR_TAG   = 8'hA5
) (
    input logic clk_w,
    input logic rst_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int SW = $clog2(N_SRC);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
    state_t          state, state_nx;
    logic [SW-1:0]   rr_ptr, win, idx, cur_src;
    logic [BW-1:0]   beat_cnt;
    logic [WCNT_W:0] free;
    logic            space_ok, cur_valid, xfer, done;
    // room for the header plus a full burst, so a granted burst never waits on space
    assign free      = (WCNT_W+1)'(DEPTH_W) - {1'b0, bus.fifo_w_cnt};
    assign space_ok  = free >= (WCNT_W+1)'(MAX_BURST + 1);
    assign cur_valid = bus.src_valid[cur_src];
    assign xfer      = state == DATA && cur_valid && !bus.fifo_full;
    assign done      = xfer && (bus.src_last[cur_src] || beat_cnt == BW'(MAX_BURST - 1));
    // scan from rr_ptr upward; iterating backwards lets the nearest requester win
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = SW'((int'(rr_ptr) + k) % N_SRC);
            if (bus.src_valid[idx]) win = idx;
        end
    end
    always_comb begin
        state_nx = state == IDLE ? ((|bus.src_valid && space_ok) ? HDR : IDLE)
                 : state == HDR  ? (bus.fifo_full ? HDR : DATA)
                 : (done ? IDLE : DATA);
    end
    // outputs also gated by rst_n so the reset cycle itself never writes
    assign bus.fifo_w_req  = rst_n && !bus.fifo_full && (state == HDR || (state == DATA && cur_valid));
    assign bus.src_ready   = (rst_n && state == DATA && !bus.fifo_full) ? N_SRC'(1) << cur_src : '0;
    assign bus.fifo_data_i = state == HDR  ? {HDR_TAG, {(DW-8-SW){1'b0}}, cur_src}
                           : state == DATA ? bus.src_data[int'(cur_src)*DW +: DW] : '0;
    assign bus.busy        = state != IDLE;
    assign bus.cur_src     = cur_src;
    always_ff @(posedge clk_w) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_src  <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            if (state == IDLE && state_nx == HDR) cur_src <= win;
            beat_cnt <= state == HDR ? '0 : xfer ? beat_cnt + 1'b1 : beat_cnt;
        end
    end
`ifdef FIFO_ARB_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk_w) begin
        if (!rst_n) rr_ptr <= '0;
        else if (done) rr_ptr <= cur_src == SW'(N_SRC - 1) ? '0 : cur_src + 1'b1;
    end
`endif
endmodule
